// File: rtl/stage_sequencer.sv
// stage_sequencer: programmable six-stage sequencer.
// Drives the one-hot stage strobes S0..S5. Each stage is held for its dwell
// count plus one cycle. Runs use a START/BUSY/DONE handshake, can be paused
// with HOLD, and can be aborted with CLR.
module stage_sequencer #(
  parameter int DWELL_W       = 4,
  parameter int DEFAULT_DWELL = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clr,
  input  logic               i_start,
  input  logic               i_hold,
  input  logic               i_load,
  input  logic [2:0]         i_load_sel,
  input  logic [DWELL_W-1:0] i_load_val,
  output logic               o_s0,
  output logic               o_s1,
  output logic               o_s2,
  output logic               o_s3,
  output logic               o_s4,
  output logic               o_s5,
  output logic [2:0]         o_stage,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam logic [DWELL_W-1:0] DEFAULT_DW = DWELL_W'(DEFAULT_DWELL);
  localparam logic [2:0]         LAST_STAGE = 3'd5;

  // Architectural state
  state_t             r_state;
  logic [2:0]         r_stage;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] r_dw [6];

  // Registered outputs
  logic [5:0]         r_s;
  logic [2:0]         r_stage_out;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  // Next-state and decode wires
  state_t             w_state_nx;
  logic [2:0]         w_stage_nx;
  logic [DWELL_W-1:0] w_cnt_nx;
  logic [DWELL_W-1:0] w_dw_first;
  logic [DWELL_W-1:0] w_dw_succ;
  logic               w_load_ok;
  logic               w_load_bad;
  logic               w_active_nx;
  logic [5:0]         w_s_nx;

  // A load is legal only in IDLE and only for an existing register.
  // CLR outranks loads: no write and no error while it is asserted.
  assign w_load_ok  = i_load && !i_clr && (r_state == ST_IDLE) && (i_load_sel <= LAST_STAGE);
  assign w_load_bad = i_load && !i_clr && !w_load_ok;

  // A same-cycle load of DW[0] feeds straight into the run being launched.
  assign w_dw_first = (w_load_ok && (i_load_sel == 3'd0)) ? i_load_val : r_dw[0];

  // Dwell of the stage that follows the current one.
  always_comb begin
    w_dw_succ = '0;
    case (r_stage)
      3'd0:    w_dw_succ = r_dw[1];
      3'd1:    w_dw_succ = r_dw[2];
      3'd2:    w_dw_succ = r_dw[3];
      3'd3:    w_dw_succ = r_dw[4];
      3'd4:    w_dw_succ = r_dw[5];
      default: w_dw_succ = '0;
    endcase
  end

  // Next-state logic: CLR first, then HOLD, then start/advance.
  // PAUSE with HOLD low performs the RUN step right away so that a
  // pause costs exactly as many cycles as HOLD was high.
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    w_state_nx = r_state;
    w_stage_nx = r_stage;
    w_cnt_nx   = r_cnt;
    if (i_clr) begin
      w_state_nx = ST_IDLE;
      w_stage_nx = 3'd0;
      w_cnt_nx   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_state_nx = ST_RUN;
            w_stage_nx = 3'd0;
            w_cnt_nx   = w_dw_first;
          end
        end
        ST_RUN, ST_PAUSE: begin
          if (i_hold) begin
            w_state_nx = ST_PAUSE;
          end else begin
            w_state_nx = ST_RUN;
            if (r_cnt != '0) begin
              w_cnt_nx = r_cnt - DWELL_W'(1);
            end else if (r_stage < LAST_STAGE) begin
              w_stage_nx = r_stage + 3'd1;
              w_cnt_nx   = w_dw_succ;
            end else begin
              w_state_nx = ST_FIN;
              w_stage_nx = 3'd0;
              w_cnt_nx   = '0;
            end
          end
        end
        ST_FIN: begin
          w_state_nx = ST_IDLE;
          w_stage_nx = 3'd0;
          w_cnt_nx   = '0;
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_stage_nx = 3'd0;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they describe.
  assign w_active_nx = (w_state_nx == ST_RUN) || (w_state_nx == ST_PAUSE);
  assign w_s_nx      = w_active_nx ? (6'b00_0001 << w_stage_nx) : 6'b00_0000;

  // State register and registered outputs.
  always_ff @(posedge i_clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_stage     <= 3'd0;
      r_cnt       <= '0;
      r_s         <= 6'b00_0000;
      r_stage_out <= 3'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_stage     <= w_stage_nx;
      r_cnt       <= w_cnt_nx;
      r_s         <= w_s_nx;
      r_stage_out <= w_active_nx ? w_stage_nx : 3'd0;
      r_busy      <= w_active_nx;
      r_done      <= (w_state_nx == ST_FIN);
    end
  end

  // Dwell register file: writes only on legal IDLE loads.
  always_ff @(posedge i_clk) begin
    // NOTE: this small register file is reset on purpose; runs after reset
    // must use the default dwell, so it cannot be left uninitialised.
    if (i_reset) begin
      for (int i = 0; i < 6; i++) r_dw[i] <= DEFAULT_DW;
    end else if (w_load_ok) begin
      for (int i = 0; i < 6; i++) begin
        if (i_load_sel == 3'(i)) r_dw[i] <= i_load_val;
      end
    end
  end

  // Sticky illegal-load flag, cleared by RESET or CLR.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_err <= 1'b0;
    end else if (w_load_bad) begin
      r_err <= 1'b1;
    end
  end

  assign o_s0    = r_s[0];
  assign o_s1    = r_s[1];
  assign o_s2    = r_s[2];
  assign o_s3    = r_s[3];
  assign o_s4    = r_s[4];
  assign o_s5    = r_s[5];
  assign o_stage = r_stage_out;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_err   = r_err;

endmodule

// File: tb/tb_stage_sequencer.sv
// Testbench for stage_sequencer: directed stimulus with a scoreboard.
// The stimulus thread pushes the expected per-stage run profile; a monitor
// measures each run and pops/compares when DONE is presented.
module tb_stage_sequencer;

  localparam int DW_W = 4;

  logic            i_clk = 1'b0;
  logic            i_reset = 1'b0;
  logic            i_clr = 1'b0;
  logic            i_start = 1'b0;
  logic            i_hold = 1'b0;
  logic            i_load = 1'b0;
  logic [2:0]      i_load_sel = 3'd0;
  logic [DW_W-1:0] i_load_val = '0;
  logic            o_s0, o_s1, o_s2, o_s3, o_s4, o_s5;
  logic [2:0]      o_stage;
  logic            o_busy, o_done, o_err;

  stage_sequencer #(.DWELL_W(DW_W), .DEFAULT_DWELL(0)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clr      (i_clr),
    .i_start    (i_start),
    .i_hold     (i_hold),
    .i_load     (i_load),
    .i_load_sel (i_load_sel),
    .i_load_val (i_load_val),
    .o_s0       (o_s0),
    .o_s1       (o_s1),
    .o_s2       (o_s2),
    .o_s3       (o_s3),
    .o_s4       (o_s4),
    .o_s5       (o_s5),
    .o_stage    (o_stage),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [5:0][7:0] len;
    logic [15:0]     busy;
  } run_t;

  run_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   tb_dw[6];
  bit   mon_en = 1'b0;

  logic [5:0] s_vec;
  assign s_vec = {o_s5, o_s4, o_s3, o_s2, o_s1, o_s0};

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  int mon_len[6];
  int mon_busy;
  int mon_prev;

  initial begin
    foreach (mon_len[i]) mon_len[i] = 0;
    mon_busy = 0;
    mon_prev = 0;
    forever begin
      @(negedge i_clk);
      if (mon_en) begin
        if (o_busy) begin
          check("strobe_decode", int'(s_vec), int'(6'b00_0001 << o_stage));
          check("stage_order", (int'(o_stage) >= mon_prev) ? 1 : 0, 1);
          mon_len[o_stage]++;
          mon_busy++;
          mon_prev = int'(o_stage);
        end else begin
          check("idle_strobes", int'(s_vec), 0);
          check("idle_stage", int'(o_stage), 0);
          if (o_done) begin
            if (exp_q.size() == 0) begin
              check("unexpected_done", 1, 0);
            end else begin
              run_t e;
              e = exp_q.pop_front();
              for (int i = 0; i < 6; i++) check($sformatf("stage%0d_len", i), mon_len[i], int'(e.len[i]));
              check("busy_len", mon_busy, int'(e.busy));
            end
          end
          foreach (mon_len[i]) mon_len[i] = 0;
          mon_busy = 0;
          mon_prev = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    foreach (tb_dw[i]) tb_dw[i] = 0;
  endtask

  task automatic pulse_clr();
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
  endtask

  task automatic load(input int sel, input int val);
    i_load     = 1'b1;
    i_load_sel = 3'(sel);
    i_load_val = DW_W'(val);
    tick();
    i_load = 1'b0;
    if (sel <= 5) tb_dw[sel] = val;
  endtask

  // One full run. hold_at/hold_len: HOLD high on those cycles after the
  // START edge, stretching stage hold_stg. load_at: illegal mid-run load.
  // ld0 >= 0: LOAD DW[0]=ld0 together with START. start_in_fin: pulse
  // START during the DONE cycle, which must be ignored.
  task automatic run_seq(input int hold_at, input int hold_len, input int hold_stg,
                         input int load_at, input int ld0, input bit start_in_fin);
    run_t e;
    int   sum;
    int   cyc;
    if (ld0 >= 0) tb_dw[0] = ld0;
    sum = 0;
    for (int i = 0; i < 6; i++) begin
      int l;
      l = tb_dw[i] + 1 + ((i == hold_stg) ? hold_len : 0);
      e.len[i] = 8'(l);
      sum += l;
    end
    e.busy = 16'(sum);
    exp_q.push_back(e);

    if (ld0 >= 0) begin
      i_load     = 1'b1;
      i_load_sel = 3'd0;
      i_load_val = DW_W'(ld0);
    end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_load  = 1'b0;
    cyc = 1;
    check("start_s0", int'(o_s0), 1);
    check("start_busy", int'(o_busy), 1);
    while (!o_done && cyc < 400) begin
      i_hold     = (hold_len > 0) && (cyc >= hold_at) && (cyc < hold_at + hold_len);
      i_load     = (cyc == load_at);
      i_load_sel = 3'd1;
      i_load_val = 4'd7;
      tick();
      cyc++;
    end
    i_hold = 1'b0;
    i_load = 1'b0;
    check("done_cycle", cyc, sum + 1);
    if (start_in_fin) i_start = 1'b1;
    tick();
    i_start = 1'b0;
    if (start_in_fin) begin
      check("fin_start_busy", int'(o_busy), 0);
      tick();
      check("fin_start_busy2", int'(o_busy), 0);
    end
  endtask

  // Launch an unscored run and stop when the given stage is reached.
  task automatic start_until_stage(input int stg);
    int cyc;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    cyc = 0;
    while (int'(o_stage) != stg && cyc < 100) begin
      tick();
      cyc++;
    end
    check("reach_stage", int'(o_stage), stg);
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    do_reset();
    check("rst_strobes", int'(s_vec), 0);
    check("rst_stage", int'(o_stage), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_err", int'(o_err), 0);
    mon_en = 1'b1;

    // Default run: all dwells zero, DONE on cycle 7.
    run_seq(0, 0, 0, 0, -1, 1'b0);
    check("default_err", int'(o_err), 0);

    // Programmed dwells {2,0,3,1,0,4}: 16 busy cycles.
    load(0, 2); load(1, 0); load(2, 3); load(3, 1); load(4, 0); load(5, 4);
    check("load_err", int'(o_err), 0);
    run_seq(0, 0, 0, 0, -1, 1'b0);

    // Pause in S2's second cycle (cycle 6) for 5 cycles: S2 lasts 9.
    run_seq(6, 5, 2, 0, -1, 1'b0);

    // HOLD in S0's last cycle delays the advance; START during FIN ignored.
    run_seq(3, 1, 0, 0, -1, 1'b1);

    // Abort in S3, then a fresh run keeps the programmed dwells.
    start_until_stage(3);
    pulse_clr();
    check("abort_strobes", int'(s_vec), 0);
    check("abort_busy", int'(o_busy), 0);
    check("abort_done", int'(o_done), 0);
    tick();
    check("abort_no_done", int'(o_done), 0);
    run_seq(0, 0, 0, 0, -1, 1'b0);

    // Illegal index in IDLE: ERR sets, dwells unchanged.
    load(6, 9);
    check("err_sel6", int'(o_err), 1);
    run_seq(0, 0, 0, 0, -1, 1'b0);
    check("err_sticky", int'(o_err), 1);
    pulse_clr();
    check("err_clr", int'(o_err), 0);

    // Load during RUN: ERR sets and the run is unaffected.
    run_seq(0, 0, 0, 4, -1, 1'b0);
    check("err_run_load", int'(o_err), 1);
    pulse_clr();
    check("err_clr2", int'(o_err), 0);

    // START together with CLR in IDLE: no run.
    i_start = 1'b1;
    i_clr   = 1'b1;
    tick();
    i_start = 1'b0;
    i_clr   = 1'b0;
    check("start_clr_busy", int'(o_busy), 0);
    tick();
    check("start_clr_busy2", int'(o_busy), 0);

    // LOAD(sel 0, val 2) with START: the run uses the new DW[0].
    load(0, 5);
    run_seq(0, 0, 0, 0, 2, 1'b0);

    // RESET during S4: idle outputs at once, dwells back to default.
    start_until_stage(4);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    foreach (tb_dw[i]) tb_dw[i] = 0;
    check("midrst_strobes", int'(s_vec), 0);
    check("midrst_busy", int'(o_busy), 0);
    check("midrst_done", int'(o_done), 0);
    check("midrst_stage", int'(o_stage), 0);
    tick();
    check("midrst_no_done", int'(o_done), 0);
    run_seq(0, 0, 0, 0, -1, 1'b0);

    tick();
    tick();
    check("pending_runs", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Programmable six-stage sequencer that drives the one-hot stage strobes S0–S5 of the project's control datapath. Each stage is held for a per-stage dwell count loaded from a small register file. Runs are launched with a START/BUSY/DONE handshake and can be paused (HOLD) or aborted (CLR). It sits between the host/test logic and the datapath, replacing free-running stage stepping with scheduled, repeatable sequences.

## Interface
Parameters:
- DWELL_W, 4, width of each dwell register and the dwell counter.
- DEFAULT_DWELL, 0, reset value of all six dwell registers; must fit in DWELL_W bits.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- CLR  in  1  synchronous abort: returns the FSM to IDLE; dwell registers are kept.
- START  in  1  run request; sampled only in IDLE.
- HOLD  in  1  level pause; freezes the stage and counter while in RUN.
- LOAD  in  1  write strobe for the dwell register file.
- LOAD_SEL  in  3  dwell register index; valid values 0–5.
- LOAD_VAL  in  DWELL_W  dwell value to write.
- S0..S5  out  1 each  one-hot stage strobes; all 0 outside RUN/PAUSE.
- STAGE  out  3  binary index of the active stage; 0 when not running.
- BUSY  out  1  high in RUN and PAUSE.
- DONE  out  1  single-cycle pulse on run completion.
- ERR  out  1  sticky illegal-load flag.

## Operation
- Dwell register DW[i] (i = 0..5). Stage i is held for DW[i]+1 cycles. Value 0 gives 1 cycle; maximum is 2^DWELL_W cycles.
- FSM states are IDLE, RUN, PAUSE and FIN.
  - **IDLE:** START=1 → RUN, with stage=0 and cnt=DW[0].
  - **RUN:**
    - HOLD=1 → PAUSE. Stage and cnt are unchanged.
    - Otherwise, if cnt≠0, cnt decrements.
    - Otherwise, if stage<5, stage increments and cnt loads DW[stage+1].
    - Otherwise (stage 5, cnt 0) → FIN.
  - **PAUSE:** HOLD=0 → RUN. Counting resumes where it stopped, with no lost or extra cycle.
  - **FIN:** DONE=1 for exactly one cycle, then → IDLE. START during FIN is ignored.
- Priority is RESET > CLR > HOLD > START/advance.
- **CLR:** in any state, the next state is IDLE and all outputs are idle values. DW[] is unchanged and ERR is cleared. CLR in the same cycle as START means no run starts.
- **Loading dwell registers:**
  - LOAD is accepted only in IDLE with LOAD_SEL ≤ 5: DW[LOAD_SEL] ← LOAD_VAL on that edge.
  - LOAD with LOAD_SEL 6 or 7, or LOAD in any state other than IDLE, performs no write and sets ERR=1. ERR stays set until RESET or CLR.
  - LOAD and START in the same IDLE cycle: the write takes effect, and the run uses the new value if LOAD_SEL=0.
- **Outputs** are registered and decoded from state/stage.
  - S[stage]=1 only in RUN or PAUSE; S outputs are held during PAUSE.
  - At most one S output is high in any cycle.
- **Reset values:**
  - S0..S5=0, STAGE=0, BUSY=0, DONE=0, ERR=0.
  - FSM=IDLE, cnt=0, DW[0..5]=DEFAULT_DWELL.

## Timing
- Run latency: START high at edge k → S0=1 and BUSY=1 after edge k.
- Run length:
  - BUSY stays high for Σ(DW[i]+1) cycles plus the total number of HOLD cycles.
  - DONE is high for the single cycle after BUSY falls.
  - START is next accepted one cycle after DONE.
- All-zero dwells: S0..S5 are each high for one cycle on cycles 1–6 after the START edge, and DONE is high on cycle 7.
- Stage handoff has no gap: S(i) falls and S(i+1) rises on the same edge.
- HOLD asserted in the last cycle of a stage: the advance is suppressed and occurs 1 cycle after HOLD drops.
- RESET mid-run: all outputs are at reset values after that edge, with no DONE pulse.

## Test plan
- **Reset and default run:** reset, START for 1 cycle → S0..S5 each high 1 cycle in order, DONE on cycle 7, ERR=0.
- **Programmed dwells:** load DW = {2,0,3,1,0,4}, then START → stage lengths 3,1,4,2,1,5 cycles, BUSY for 16 cycles, single DONE pulse. Check one-hot on every cycle.
- **Pause:** with DW[2]=3, HOLD for 5 cycles starting in S2's second cycle → S2 lasts 9 cycles total, counting resumes exactly, BUSY length = base + 5.
- **Abort:** CLR while in S3 → next cycle all S=0, BUSY=0, no DONE. A new START runs with the programmed DW (not reset to default).
- **Error flag:** LOAD with LOAD_SEL=6 in IDLE → ERR=1 with DW unchanged. LOAD with LOAD_SEL=1 during RUN → ERR=1 with the run unaffected. CLR → ERR=0.
- **Simultaneous events:**
  - START+CLR in IDLE → no run.
  - START during FIN → ignored.
  - LOAD(sel 0, val 2)+START → S0 lasts 3 cycles.
  - RESET during S4 → reset values and DW=DEFAULT_DWELL.
